// File: rtl/logic_unit_pkg.sv
// Shared encodings for the iterative logic unit: operation select and controller states.
package logic_unit_pkg;

    typedef enum logic [1:0] {
        OP_AND = 2'b00,
        OP_OR  = 2'b01,
        OP_XOR = 2'b10,
        OP_NOR = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

endpackage

// File: rtl/logic_slice.sv
// Combinational SLICE-bit bitwise operator used once per RUN cycle.
module logic_slice
    import logic_unit_pkg::*;
#(
    parameter int SLICE = 8
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  op_e              op,
    output logic [SLICE-1:0] y
);

    always_comb begin
        y = '0;
        case (op)
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_NOR:  y = ~(a | b);
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/logic_unit_iter.sv
// Iterative bitwise logic unit: one SLICE-bit chunk per cycle, valid/ready on both sides.
// Optional result-is-zero output enabled by defining ZERO_FLAG_EN.
module logic_unit_iter
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result
`ifdef ZERO_FLAG_EN
    ,
    output logic             zero
`endif
);

    localparam int NSL = WIDTH / SLICE;
    localparam int CW  = (NSL > 1) ? $clog2(NSL) : 1;

    generate
        if (WIDTH % SLICE != 0) begin : g_bad_slice
            $error("logic_unit_iter: WIDTH must be a multiple of SLICE");
        end
    endgenerate

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    op_e              op_q, op_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [SLICE-1:0] sa, sb, sy;
`ifdef ZERO_FLAG_EN
    // Sticky "some slice was non-zero"; zero is its inverse while DONE.
    logic             nz_q, nz_d;
`endif

    // Select the operand slice addressed by the counter.
    always_comb begin
        sa = '0;
        sb = '0;
        for (int i = 0; i < NSL; i++) begin
            if (cnt_q == CW'(i)) begin
                sa = a_q[i*SLICE +: SLICE];
                sb = b_q[i*SLICE +: SLICE];
            end
        end
    end

    logic_slice #(.SLICE(SLICE)) u_slice (
        .a  (sa),
        .b  (sb),
        .op (op_q),
        .y  (sy)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        result_d = result_q;
`ifdef ZERO_FLAG_EN
        nz_d     = nz_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_d      = A;
                    b_d      = B;
                    op_d     = op_e'(op);
                    cnt_d    = '0;
                    result_d = '0;
`ifdef ZERO_FLAG_EN
                    nz_d     = 1'b0;
`endif
                    state_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                for (int i = 0; i < NSL; i++) begin
                    if (cnt_q == CW'(i)) result_d[i*SLICE +: SLICE] = sy;
                end
`ifdef ZERO_FLAG_EN
                nz_d = nz_q | (|sy);
`endif
                // Counter parks on the last slice rather than wrapping.
                if (cnt_q == CW'(NSL - 1)) state_d = ST_DONE;
                else                       cnt_d   = cnt_q + CW'(1);
            end
            ST_DONE: begin
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= OP_AND;
            result_q <= '0;
`ifdef ZERO_FLAG_EN
            nz_q     <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            result_q <= result_d;
`ifdef ZERO_FLAG_EN
            nz_q     <= nz_d;
`endif
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign result    = result_q;
`ifdef ZERO_FLAG_EN
    assign zero      = out_valid & ~nz_q;
`endif

endmodule

// File: tb/tb_logic_unit_iter.sv
// Self-checking bench for logic_unit_iter: vector table, random ops vs. a bitwise model, and handshake/reset corners.
module tb_logic_unit_iter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, in_valid, in_ready, out_valid, out_ready;
    logic [1:0]  op;
    logic [31:0] A, B, result;
    logic        zero;

    logic        in_valid2, in_ready2, out_valid2, out_ready2;
    logic [1:0]  op2;
    logic [15:0] A2, B2, result2;
    logic        zero2;

    logic_unit_iter #(.WIDTH(32), .SLICE(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .A(A), .B(B), .out_valid(out_valid), .out_ready(out_ready),
        .result(result)
`ifdef ZERO_FLAG_EN
        , .zero(zero)
`endif
    );

    logic_unit_iter #(.WIDTH(16), .SLICE(16)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
        .op(op2), .A(A2), .B(B2), .out_valid(out_valid2), .out_ready(out_ready2),
        .result(result2)
`ifdef ZERO_FLAG_EN
        , .zero(zero2)
`endif
    );

`ifndef ZERO_FLAG_EN
    assign zero  = 1'b0;
    assign zero2 = 1'b0;
`endif

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_op(input logic [31:0] a, input logic [31:0] b, input logic [1:0] o);
        case (o)
            2'd0:    return a & b;
            2'd1:    return a | b;
            2'd2:    return a ^ b;
            default: return ~(a | b);
        endcase
    endfunction

    // Issue one request from IDLE; return when out_valid is seen (or budget expires).
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [1:0] o,
                          output logic [31:0] res, output int lat);
        @(negedge clk);
        A = a; B = b; op = o; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        res = result;
    endtask

    task automatic release_out(input string name);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({name, "_in_ready_after"}, 32'(in_ready), 32'd1);
        chk({name, "_out_valid_after"}, 32'(out_valid), 32'd0);
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  op;
        logic [31:0] exp;
    } vec_t;

    initial begin
        vec_t        tbl[5];
        logic [31:0] res, held, ra, rb, exp;
        logic [1:0]  ro;
        int          lat;

        tbl[0] = '{32'hFFFF0000, 32'h0F0F0F0F, 2'b00, 32'h0F0F0000};
        tbl[1] = '{32'hFFFF0000, 32'h0F0F0F0F, 2'b01, 32'hFFFF0F0F};
        tbl[2] = '{32'hFFFF0000, 32'h0F0F0F0F, 2'b10, 32'hF0F00F0F};
        tbl[3] = '{32'hFFFF0000, 32'h0F0F0F0F, 2'b11, 32'h0000F0F0};
        tbl[4] = '{32'h12345678, 32'h12345678, 2'b10, 32'h00000000};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; op = '0; A = '0; B = '0;
        in_valid2 = 1'b0; out_ready2 = 1'b0; op2 = '0; A2 = '0; B2 = '0;
        #1;
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_result", result, 32'd0);
        chk("reset_zero", 32'(zero), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Vector table
        for (int i = 0; i < 5; i++) begin
            run_op(tbl[i].a, tbl[i].b, tbl[i].op, res, lat);
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd4);
            chk($sformatf("vec%0d_result", i), res, tbl[i].exp);
`ifdef ZERO_FLAG_EN
            chk($sformatf("vec%0d_zero", i), 32'(zero), 32'(tbl[i].exp == 32'd0));
`endif
            release_out($sformatf("vec%0d", i));
        end

        // Hold in DONE for 10 cycles with out_ready low
        run_op(32'hDEADBEEF, 32'h0000FFFF, 2'b01, held, lat);
        chk("hold_result_initial", held, 32'hDEADFFFF);
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            chk("hold_result", result, held);
            chk("hold_out_valid", 32'(out_valid), 32'd1);
            chk("hold_in_ready", 32'(in_ready), 32'd0);
        end
        release_out("hold");

        // Inputs churn during RUN; in_valid stays high through DONE and the release edge
        @(negedge clk);
        A = 32'hA5A5A5A5; B = 32'h3C3C3C3C; op = 2'b10; in_valid = 1'b1;
        @(posedge clk); #1;
        lat = 0;
        while (!out_valid && lat < 50) begin
            A = $urandom; B = $urandom; op = 2'($urandom_range(0, 3));
            @(posedge clk); #1;
            lat++;
        end
        chk("toggle_latency", 32'(lat), 32'd4);
        chk("toggle_result", result, 32'h99999999);
        chk("toggle_in_ready_done", 32'(in_ready), 32'd0);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("toggle_no_release_accept", 32'(in_ready), 32'd1);
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("toggle_still_idle", 32'(in_ready), 32'd1);

        // Reset asserted during the second RUN cycle
        @(negedge clk);
        A = 32'hFFFFFFFF; B = 32'h0000FFFF; op = 2'b01; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("midrun_rst_in_ready", 32'(in_ready), 32'd1);
        chk("midrun_rst_out_valid", 32'(out_valid), 32'd0);
        chk("midrun_rst_result", result, 32'd0);
        chk("midrun_rst_zero", 32'(zero), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            chk("post_rst_no_out_valid", 32'(out_valid), 32'd0);
        end

        // Randomized ops against the bitwise model
        for (int i = 0; i < 20; i++) begin
            ra = $urandom; rb = $urandom; ro = 2'($urandom_range(0, 3));
            if (i == 0) rb = ra;
            exp = ref_op(ra, rb, ro);
            run_op(ra, rb, ro, res, lat);
            chk($sformatf("rnd%0d_latency", i), 32'(lat), 32'd4);
            chk($sformatf("rnd%0d_result", i), res, exp);
`ifdef ZERO_FLAG_EN
            chk($sformatf("rnd%0d_zero", i), 32'(zero), 32'(exp == 32'd0));
`endif
            release_out($sformatf("rnd%0d", i));
        end

        // Single-slice instance: one RUN cycle
        @(negedge clk);
        A2 = 16'hAAAA; B2 = 16'h5555; op2 = 2'b11; in_valid2 = 1'b1;
        @(posedge clk); #1;
        in_valid2 = 1'b0;
        lat = 0;
        while (!out_valid2 && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("w16_latency", 32'(lat), 32'd1);
        chk("w16_result", 32'(result2), 32'h0000);
`ifdef ZERO_FLAG_EN
        chk("w16_zero", 32'(zero2), 32'd1);
`endif
        @(negedge clk);
        out_ready2 = 1'b1;
        @(posedge clk); #1;
        out_ready2 = 1'b0;
        chk("w16_in_ready_after", 32'(in_ready2), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
